// File: rtl/bf16_divide.sv
// bfloat16 divider: special operands resolve in one step, normal operands go through
// a 9-cycle restoring divide, one normalise cycle, then wait in DONE for the consumer.
module bf16_divide (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic        inexact,
  output logic        div_by_zero,
  output logic        sNaN,
  output logic        qNaN,
  output logic        normal,
  output logic        inf,
  output logic        zero
);

  localparam int F_OVF  = 9;
  localparam int F_UNF  = 8;
  localparam int F_INV  = 7;
  localparam int F_INX  = 6;
  localparam int F_DBZ  = 5;
  localparam int F_QNAN = 3;
  localparam int F_NORM = 2;
  localparam int F_INF  = 1;
  localparam int F_ZERO = 0;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_exp_q, b_exp_q;
  logic [7:0]  b_sig_q;
  logic        sign_q;
  logic [8:0]  rem_q;
  logic [8:0]  quo_q;
  logic [3:0]  cnt_q;
  logic [15:0] res_q;
  logic [9:0]  flags_q;

  logic accept;
  assign accept = in_valid & in_ready;

  // Operand classification straight from the inputs; subnormals count as zero.
  logic a_nan, a_snan, a_inf, a_zero, b_nan, b_snan, b_inf, b_zero, sign_in;
  assign a_nan   = (A[14:7] == 8'hFF) && (A[6:0] != 7'd0);
  assign b_nan   = (B[14:7] == 8'hFF) && (B[6:0] != 7'd0);
  assign a_snan  = a_nan && !A[6];
  assign b_snan  = b_nan && !B[6];
  assign a_inf   = (A[14:7] == 8'hFF) && (A[6:0] == 7'd0);
  assign b_inf   = (B[14:7] == 8'hFF) && (B[6:0] == 7'd0);
  assign a_zero  = (A[14:7] == 8'h00);
  assign b_zero  = (B[14:7] == 8'h00);
  assign sign_in = A[15] ^ B[15];

  logic        spec_hit;
  logic [15:0] spec_res;
  logic [9:0]  spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = 16'h0000;
    spec_flags = 10'd0;
    if (a_snan) begin
      spec_res = A | 16'h0040;
      spec_flags[F_QNAN] = 1'b1;
      spec_flags[F_INV]  = 1'b1;
    end else if (b_snan) begin
      spec_res = B | 16'h0040;
      spec_flags[F_QNAN] = 1'b1;
      spec_flags[F_INV]  = 1'b1;
    end else if (a_nan) begin
      spec_res = A;
      spec_flags[F_QNAN] = 1'b1;
    end else if (b_nan) begin
      spec_res = B;
      spec_flags[F_QNAN] = 1'b1;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = 16'h7FC0;
      spec_flags[F_QNAN] = 1'b1;
      spec_flags[F_INV]  = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, 8'hFF, 7'd0};
      spec_flags[F_INF] = 1'b1;
    end else if (b_inf) begin
      spec_res = {sign_in, 15'd0};
      spec_flags[F_ZERO] = 1'b1;
    end else if (b_zero) begin
      spec_res = {sign_in, 8'hFF, 7'd0};
      spec_flags[F_INF] = 1'b1;
      spec_flags[F_DBZ] = 1'b1;
    end else if (a_zero) begin
      spec_res = {sign_in, 15'd0};
      spec_flags[F_ZERO] = 1'b1;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step; the subtracted remainder is below b_sig so the shift cannot overflow.
  logic       step_bit;
  logic [8:0] rem_sub, rem_step;
  assign step_bit = (rem_q >= {1'b0, b_sig_q});
  assign rem_sub  = step_bit ? (rem_q - {1'b0, b_sig_q}) : rem_q;
  assign rem_step = {rem_sub[7:0], 1'b0};

  logic signed [9:0] exp_bias, exp_e;
  logic [7:0]        norm_sig;
  logic              norm_lost;
  logic [15:0]       norm_res;
  logic [9:0]        norm_flags;

  always_comb begin
    exp_bias   = quo_q[8] ? 10'sd127 : 10'sd126;
    exp_e      = $signed({2'b00, a_exp_q}) - $signed({2'b00, b_exp_q}) + exp_bias;
    norm_sig   = quo_q[8] ? quo_q[8:1] : quo_q[7:0];
    norm_lost  = (quo_q[8] && quo_q[0]) || (rem_q != 9'd0);
    norm_res   = 16'h0000;
    norm_flags = 10'd0;
    if (exp_e >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 7'd0};
      norm_flags[F_INF] = 1'b1;
      norm_flags[F_OVF] = 1'b1;
      norm_flags[F_INX] = 1'b1;
    end else if (exp_e <= 10'sd0) begin
      norm_res = {sign_q, 15'd0};
      norm_flags[F_ZERO] = 1'b1;
      norm_flags[F_UNF]  = 1'b1;
      norm_flags[F_INX]  = 1'b1;
    end else begin
      norm_res = {sign_q, exp_e[7:0], norm_sig[6:0]};
      norm_flags[F_NORM] = 1'b1;
      norm_flags[F_INX]  = norm_lost;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = spec_hit ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == 4'd8) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_exp_q <= 8'd0;
      b_exp_q <= 8'd0;
      b_sig_q <= 8'd0;
      sign_q  <= 1'b0;
      rem_q   <= 9'd0;
      quo_q   <= 9'd0;
      cnt_q   <= 4'd0;
      res_q   <= 16'h0000;
      flags_q <= 10'd0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_exp_q <= A[14:7];
          b_exp_q <= B[14:7];
          b_sig_q <= {1'b1, B[6:0]};
          sign_q  <= sign_in;
          rem_q   <= {2'b01, A[6:0]};
          quo_q   <= 9'd0;
          cnt_q   <= 4'd0;
          if (spec_hit) begin
            res_q   <= spec_res;
            flags_q <= spec_flags;
          end
        end
        DIVIDE: begin
          rem_q <= rem_step;
          quo_q <= {quo_q[7:0], step_bit};
          cnt_q <= cnt_q + 4'd1;
        end
        NORM: begin
          res_q   <= norm_res;
          flags_q <= norm_flags;
        end
        default: ;
      endcase
    end
  end

  assign q = res_q;
  assign {overflow, underflow, invalid, inexact, div_by_zero,
          sNaN, qNaN, normal, inf, zero} = flags_q;

endmodule

// File: tb/tb_bf16_divide.sv
// Bench for bf16_divide: directed literal cases plus randomized operands checked
// every valid cycle against an arithmetic reference model.
module tb_bf16_divide;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, q;
  logic        overflow, underflow, invalid, inexact, div_by_zero;
  logic        sNaN, qNaN, normal, inf, zero;

  bf16_divide dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .q(q),
    .overflow(overflow), .underflow(underflow), .invalid(invalid),
    .inexact(inexact), .div_by_zero(div_by_zero), .sNaN(sNaN), .qNaN(qNaN),
    .normal(normal), .inf(inf), .zero(zero)
  );

  // flag vector order: ovf unf inv inx dbz snan qnan normal inf zero
  localparam logic [9:0] FL_OVF = 10'h200, FL_UNF = 10'h100, FL_INV = 10'h080,
                         FL_INX = 10'h040, FL_DBZ = 10'h020, FL_QNAN = 10'h008,
                         FL_NORM = 10'h004, FL_INF = 10'h002, FL_ZERO = 10'h001;

  logic [9:0] dut_fl;
  assign dut_fl = {overflow, underflow, invalid, inexact, div_by_zero,
                   sNaN, qNaN, normal, inf, zero};

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q;
  logic [9:0]  exp_fl;
  bit          exp_armed = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic        spec;
    logic [15:0] q;
    logic [9:0]  fl;
  } res_t;

  // Reference: classify, then divide the significands as plain integers.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int ea = int'(a[14:7]);
    int eb = int'(b[14:7]);
    bit s = a[15] ^ b[15];
    bit an = (ea == 255) && (a[6:0] != 0);
    bit bn = (eb == 255) && (b[6:0] != 0);
    bit asn = an && !a[6];
    bit bsn = bn && !b[6];
    bit ai = (ea == 255) && (a[6:0] == 0);
    bit bi = (eb == 255) && (b[6:0] == 0);
    bit az = (ea == 0);
    bit bz = (eb == 0);
    r.spec = 1;
    r.fl = 0;
    r.q = 0;
    if (asn)                      begin r.q = a | 16'h0040; r.fl = FL_QNAN | FL_INV; end
    else if (bsn)                 begin r.q = b | 16'h0040; r.fl = FL_QNAN | FL_INV; end
    else if (an)                  begin r.q = a; r.fl = FL_QNAN; end
    else if (bn)                  begin r.q = b; r.fl = FL_QNAN; end
    else if ((ai && bi) || (az && bz)) begin r.q = 16'h7FC0; r.fl = FL_QNAN | FL_INV; end
    else if (ai)                  begin r.q = {s, 8'hFF, 7'd0}; r.fl = FL_INF; end
    else if (bi)                  begin r.q = {s, 15'd0}; r.fl = FL_ZERO; end
    else if (bz)                  begin r.q = {s, 8'hFF, 7'd0}; r.fl = FL_INF | FL_DBZ; end
    else if (az)                  begin r.q = {s, 15'd0}; r.fl = FL_ZERO; end
    else begin
      int sa = 128 + int'(a[6:0]);
      int sb = 128 + int'(b[6:0]);
      int qq = (sa * 256) / sb;
      int rm = (sa * 256) % sb;
      int e = ea - eb + 127;
      int sig;
      bit lost;
      r.spec = 0;
      if (qq >= 256) begin sig = qq / 2; lost = (qq % 2) != 0; end
      else begin sig = qq; lost = 0; e = e - 1; end
      if (e >= 255)     begin r.q = {s, 8'hFF, 7'd0}; r.fl = FL_INF | FL_OVF | FL_INX; end
      else if (e <= 0)  begin r.q = {s, 15'd0}; r.fl = FL_ZERO | FL_UNF | FL_INX; end
      else begin
        logic [7:0] e8 = 8'(e);
        logic [7:0] s8 = 8'(sig);
        r.q = {s, e8, s8[6:0]};
        r.fl = FL_NORM | ((lost || rm != 0) ? FL_INX : 10'd0);
      end
    end
    return r;
  endfunction

  // Every valid cycle: result must match the model and carry exactly one class flag.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!exp_armed) chk("spurious_out_valid", 32'(out_valid), 32'd0);
      else begin
        chk("result", {q, dut_fl}, {exp_q, exp_fl});
        chk("one_class_flag", $countones(dut_fl[4:0]), 32'd1);
        chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                        input bit has_lit, input logic [15:0] lit_q, input logic [9:0] lit_fl);
    res_t m;
    int lat, w;
    logic [25:0] snap;
    m = model(a, b);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    A = a; B = b; in_valid = 1; out_ready = 0;
    exp_q = m.q; exp_fl = m.fl;
    @(posedge clk);
    exp_armed = 1;
    #1;
    A = 16'($urandom); B = 16'($urandom);  // ignored while busy
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    in_valid = 0;
    chk($sformatf("latency_%h_%h", a, b), lat, m.spec ? 32'd1 : 32'd11);
    if (has_lit) chk($sformatf("literal_%h_%h", a, b), {q, dut_fl}, {lit_q, lit_fl});
    snap = {q, dut_fl};
    repeat (stall) @(negedge clk);
    if (stall > 0) chk("hold_stable", {q, dut_fl}, snap);
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("no_same_cycle_accept", 32'(in_ready), 32'd1);
    exp_armed = 0;
    out_ready = 0;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v[14:7] = 8'h00;
      1: begin v[14:7] = 8'hFF; v[6:0] = 7'd0; end
      2: begin v[14:7] = 8'hFF; if (v[6:0] == 0) v[0] = 1'b1; end
      3: v[14:7] = ($urandom_range(0, 1) != 0) ? 8'(254 - $urandom_range(0, 3)) : 8'(1 + $urandom_range(0, 3));
      default: v[14:7] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  initial begin
    rst = 0; in_valid = 0; out_ready = 0; A = 0; B = 0;
    #1 rst = 1;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_q_flags", {q, dut_fl}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    run_op(16'h4040, 16'h3FC0, 0, 1, 16'h4000, FL_NORM);
    run_op(16'h3F80, 16'h4040, 0, 1, 16'h3EAA, FL_NORM | FL_INX);
    run_op(16'h3F80, 16'h0000, 0, 1, 16'h7F80, FL_INF | FL_DBZ);
    run_op(16'h0000, 16'h0000, 0, 1, 16'h7FC0, FL_QNAN | FL_INV);
    run_op(16'h7F81, 16'h3F80, 0, 1, 16'h7FC1, FL_QNAN | FL_INV);
    run_op(16'h7F00, 16'h0080, 0, 1, 16'h7F80, FL_INF | FL_OVF | FL_INX);
    run_op(16'h0080, 16'h7F00, 0, 1, 16'h0000, FL_ZERO | FL_UNF | FL_INX);
    run_op(16'h4040, 16'h3FC0, 5, 1, 16'h4000, FL_NORM);
    run_op(16'hFFC5, 16'h7F81, 0, 1, 16'h7FC1, FL_QNAN | FL_INV);
    run_op(16'h0005, 16'h8000, 0, 1, 16'h7FC0, FL_QNAN | FL_INV);

    // Abort in the fifth DIVIDE cycle.
    @(negedge clk);
    A = 16'h4040; B = 16'h3FC0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_q_flags", {q, dut_fl}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1 chk("in_ready_after_abort", 32'(in_ready), 32'd1);
    repeat (15) @(negedge clk);
    run_op(16'h4000, 16'h4000, 0, 1, 16'h3F80, FL_NORM);

    // Abort while a result waits in DONE.
    @(negedge clk);
    A = 16'h3F80; B = 16'h0000; in_valid = 1; out_ready = 0;
    @(posedge clk); #1 in_valid = 0;
    chk("done_before_abort", 32'(out_valid), 32'd1);
    #1 rst = 1;
    #1 chk("done_abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 250; i++)
      run_op(rand_op(), rand_op(), $urandom_range(0, 3), 0, 16'h0, 10'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_divide.md
BF16_DIVIDE -- requirements
Module: bf16_divide

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands
- A  in  16  bfloat16 dividend
- B  in  16  bfloat16 divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  16  bfloat16 quotient A/B
- overflow, underflow, invalid, inexact, div_by_zero  out  1 each  exception flags
- sNaN, qNaN, normal, inf, zero  out  1 each  result class flags

Function
REQ-003 SHALL use an FSM with states IDLE, DIVIDE, NORM, DONE; in_ready = (state==IDLE) and not rst.
REQ-004 SHALL accept on a rising edge with in_valid & in_ready, registering A, B, sign = A[15]^B[15].
REQ-005 SHALL ignore in_valid outside IDLE; inputs are not sampled again until return to IDLE.
REQ-006 SHALL treat subnormal operands as signed zero (exponent field 0).
REQ-007 SHALL resolve special cases in priority order, IDLE->DONE directly, out_valid high after the first edge following acceptance:
- sNaN operand: q = that operand with bit 6 set (A preferred); qNaN=1, invalid=1.
- qNaN operand: q = that operand (A preferred); qNaN=1.
- inf/inf or 0/0: q = 0x7FC0; qNaN=1, invalid=1.
- inf/finite: q = {sign,0xFF,0}; inf=1.
- finite/inf: q = {sign,15'b0}; zero=1.
- nonzero/0: q = {sign,0xFF,0}; inf=1, div_by_zero=1.
- 0/nonzero: q = {sign,15'b0}; zero=1.
REQ-008 SHALL handle all other operands (both normal) as follows:
- Restoring division on 8-bit significands (hidden 1).
- 9-bit remainder initialised to the A significand.
- In DIVIDE, each cycle: quotient bit = (rem >= bSig); if the bit is 1, rem -= bSig; then rem <<= 1.
- Exactly 9 cycles, MSB first, producing Q[8:0].
REQ-009 In NORM:
- If Q[8]=1: significand = Q[8:1], lost bit Q[0].
- Otherwise: significand = Q[7:0], exponent decremented by 1.
- Biased exponent e = expA - expB + 127 (minus 1 as above), computed signed, at least 10 bits.
REQ-010 SHALL truncate (round toward zero); inexact = 1 if any lost quotient bit or the final remainder is nonzero.
REQ-011 SHALL map the exponent:
- e >= 255: q = {sign,0xFF,0}; inf=1, overflow=1, inexact=1.
- e <= 0: q = {sign,15'b0}; zero=1, underflow=1, inexact=1.
- Otherwise: q = {sign,e[7:0],sig[6:0]}; normal=1.
REQ-012 SHALL give normal-path latency of exactly 11 edges from the acceptance edge to out_valid high: 9 DIVIDE cycles, 1 NORM cycle, then DONE.
REQ-013 In DONE:
- q and all flags are held stable while out_valid=1 and out_ready=0.
- On an edge with out_ready=1, the FSM moves to IDLE and out_valid drops.
- No new acceptance occurs in that same cycle.
REQ-014 SHALL keep q and flags registered; their values are don't-care and held from the last result while out_valid=0.
REQ-015 SHALL assert exactly one class flag with every valid result.

Reset
REQ-016 While rst is high, independent of clk:
- state=IDLE; out_valid=0; in_ready=0.
- q=0x0000; all flags=0; internal remainder/quotient/counter cleared.
REQ-017 Assertion of rst mid-DIVIDE or in DONE SHALL abort the operation; no result is produced for it.
REQ-018 SHALL have in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-019 A=0x4040 (3.0), B=0x3FC0 (1.5) -> q=0x4000, normal=1, inexact=0; out_valid exactly 11 edges after acceptance.
REQ-020 A=0x3F80, B=0x4040 -> q=0x3EAA, normal=1, inexact=1.
REQ-021 Special cases, each with out_valid 1 edge after acceptance:
- A=0x3F80, B=0x0000 -> q=0x7F80, inf=1, div_by_zero=1.
- A=0x0000, B=0x0000 -> q=0x7FC0, qNaN=1, invalid=1.
- A=0x7F81 (sNaN), B=0x3F80 -> q=0x7FC1, invalid=1.
REQ-022 A=0x7F00, B=0x0080 -> q=0x7F80, overflow=1, inexact=1.
REQ-023 A=0x0080, B=0x7F00 -> q=0x0000, zero=1, underflow=1.
REQ-024 Hold out_ready=0 for 5 cycles after out_valid -> q and flags stable.
REQ-025 Raise rst during cycle 5 of DIVIDE -> out_valid=0 immediately; after release, A=0x4000, B=0x4000 -> q=0x3F80.
